// File: rtl/mem_req_fence_gate.sv
// mem_req_fence_gate: request-side gate in front of the Vortex-to-AXI adapter.
// Passes requests through combinationally, counts outstanding reads/writes,
// caps each count, and runs a flush fence that blocks new traffic, waits for
// the counts to drain to zero and then raises a registered acknowledge.

module mem_req_fence_gate_chk (
  input logic clk,
  input logic reset,
  input logic rd_underflow,
  input logic wr_underflow
);

  // Flag retire handshakes that arrive with nothing outstanding (protocol error)
  always_ff @(posedge clk) begin
    if (reset) begin
      assert (!rd_underflow) else $warning("mem_req_fence_gate: read retire with no read outstanding");
      assert (!wr_underflow) else $warning("mem_req_fence_gate: write retire with no write outstanding");
    end
  end

endmodule

module mem_req_fence_gate #(
  parameter int DATA_WIDTH     = 512,
  parameter int ADDR_WIDTH     = 26,
  parameter int TAG_WIDTH      = 8,
  parameter int NUM_BANKS      = 2,
  parameter int MAX_RD_PENDING = 32,
  parameter int MAX_WR_PENDING = 32,
  localparam int BE_WIDTH      = DATA_WIDTH / 8,
  localparam int RD_CNT_W      = $clog2(MAX_RD_PENDING + 1),
  localparam int WR_CNT_W      = $clog2(MAX_WR_PENDING + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_req_valid,
  input  logic                  in_req_rw,
  input  logic [BE_WIDTH-1:0]   in_req_byteen,
  input  logic [ADDR_WIDTH-1:0] in_req_addr,
  input  logic [DATA_WIDTH-1:0] in_req_data,
  input  logic [TAG_WIDTH-1:0]  in_req_tag,
  output logic                  in_req_ready,
  output logic                  out_req_valid,
  output logic                  out_req_rw,
  output logic [BE_WIDTH-1:0]   out_req_byteen,
  output logic [ADDR_WIDTH-1:0] out_req_addr,
  output logic [DATA_WIDTH-1:0] out_req_data,
  output logic [TAG_WIDTH-1:0]  out_req_tag,
  input  logic                  out_req_ready,
  input  logic                  rd_rsp_fire,
  input  logic [NUM_BANKS-1:0]  wr_rsp_fire,
  input  logic                  flush_req,
  output logic                  flush_ack,
  output logic [RD_CNT_W-1:0]   rd_pending,
  output logic [WR_CNT_W-1:0]   wr_pending
);

  localparam int RET_W    = $clog2(NUM_BANKS + 1);
  localparam int WR_EXT_W = ((WR_CNT_W > RET_W) ? WR_CNT_W : RET_W) + 1;

  localparam logic [RD_CNT_W-1:0] RD_MAX = RD_CNT_W'(MAX_RD_PENDING);
  localparam logic [WR_CNT_W-1:0] WR_MAX = WR_CNT_W'(MAX_WR_PENDING);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Number of banks retiring a write this cycle
  function automatic logic [RET_W-1:0] popcount_banks(input logic [NUM_BANKS-1:0] v);
    logic [RET_W-1:0] cnt;
    cnt = {RET_W{1'b0}};
    for (int i = 0; i < NUM_BANKS; i++) begin
      cnt = cnt + RET_W'(v[i]);
    end
    return cnt;
  endfunction

  state_t                state_r;
  state_t                state_nxt_s;
  logic [RD_CNT_W-1:0]   rd_pending_r;
  logic [WR_CNT_W-1:0]   wr_pending_r;
  logic [RD_CNT_W-1:0]   rd_nxt_s;
  logic [WR_CNT_W-1:0]   wr_nxt_s;
  logic                  flush_ack_r;
  logic                  allow_s;
  logic                  rd_fire_s;
  logic                  wr_fire_s;
  logic [RET_W-1:0]      wr_ret_cnt_s;
  logic [WR_EXT_W-1:0]   wr_sum_s;
  logic [WR_EXT_W-1:0]   wr_ret_ext_s;
  logic                  rd_underflow_s;
  logic                  wr_underflow_s;

  // Gate: open only in IDLE and only while the matching count is below its cap
  always_comb begin
    allow_s = 1'b0;
    if (state_r == ST_IDLE) begin
      if (in_req_rw) begin
        allow_s = (wr_pending_r < WR_MAX);
      end else begin
        allow_s = (rd_pending_r < RD_MAX);
      end
    end else begin
      allow_s = 1'b0;
    end
  end

  assign out_req_valid  = in_req_valid && allow_s;
  assign in_req_ready   = out_req_ready && allow_s;
  assign out_req_rw     = in_req_rw;
  assign out_req_byteen = in_req_byteen;
  assign out_req_addr   = in_req_addr;
  assign out_req_data   = in_req_data;
  assign out_req_tag    = in_req_tag;

  assign rd_fire_s    = out_req_valid && out_req_ready && !out_req_rw;
  assign wr_fire_s    = out_req_valid && out_req_ready && out_req_rw;
  assign wr_ret_cnt_s = popcount_banks(wr_rsp_fire);
  assign wr_sum_s     = WR_EXT_W'(wr_pending_r) + WR_EXT_W'(wr_fire_s);
  assign wr_ret_ext_s = WR_EXT_W'(wr_ret_cnt_s);

  assign rd_underflow_s = rd_rsp_fire && !rd_fire_s && (rd_pending_r == {RD_CNT_W{1'b0}});
  assign wr_underflow_s = (wr_ret_ext_s > wr_sum_s);

  // Next read count: +1 on issue, -1 on response, clamped at zero
  always_comb begin
    rd_nxt_s = rd_pending_r;
    if (rd_fire_s && !rd_rsp_fire) begin
      rd_nxt_s = rd_pending_r + RD_CNT_W'(1);
    end else if (!rd_fire_s && rd_rsp_fire) begin
      if (rd_pending_r == {RD_CNT_W{1'b0}}) begin
        rd_nxt_s = {RD_CNT_W{1'b0}};
      end else begin
        rd_nxt_s = rd_pending_r - RD_CNT_W'(1);
      end
    end else begin
      rd_nxt_s = rd_pending_r;
    end
  end

  // Next write count: +1 on issue, minus every bank B handshake, clamped at zero
  always_comb begin
    wr_nxt_s = wr_pending_r;
    if (wr_underflow_s) begin
      wr_nxt_s = {WR_CNT_W{1'b0}};
    end else begin
      wr_nxt_s = WR_CNT_W'(wr_sum_s - wr_ret_ext_s);
    end
  end

  // Fence sequencing; DRAIN looks at next-cycle counts so DONE lands right after the last retire
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (flush_req) begin
          state_nxt_s = ST_DRAIN;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if ((rd_nxt_s == {RD_CNT_W{1'b0}}) && (wr_nxt_s == {WR_CNT_W{1'b0}})) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_DRAIN;
        end
      end
      ST_DONE: begin
        if (!flush_req) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DONE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State, counters and acknowledge registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r      <= ST_IDLE;
      rd_pending_r <= {RD_CNT_W{1'b0}};
      wr_pending_r <= {WR_CNT_W{1'b0}};
      flush_ack_r  <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      rd_pending_r <= rd_nxt_s;
      wr_pending_r <= wr_nxt_s;
      flush_ack_r  <= (state_nxt_s == ST_DONE);
    end
  end

  assign flush_ack  = flush_ack_r;
  assign rd_pending = rd_pending_r;
  assign wr_pending = wr_pending_r;

  mem_req_fence_gate_chk u_chk (
    .clk          (clk),
    .reset        (reset),
    .rd_underflow (rd_underflow_s),
    .wr_underflow (wr_underflow_s)
  );

endmodule

// File: tb/tb_mem_req_fence_gate.sv
// Testbench for mem_req_fence_gate: directed scenarios followed by random
// traffic, all checked against a count/phase reference model.

module tb_mem_req_fence_gate;

  localparam int DW   = 64;
  localparam int AW   = 26;
  localparam int TW   = 8;
  localparam int NB   = 2;
  localparam int MAXR = 4;
  localparam int MAXW = 4;
  localparam int BEW  = DW / 8;
  localparam int RCW  = $clog2(MAXR + 1);
  localparam int WCW  = $clog2(MAXW + 1);

  localparam int P_OPEN   = 0;
  localparam int P_FENCE  = 1;
  localparam int P_ACKED  = 2;

  logic           clk = 1'b0;
  logic           reset;
  logic           in_req_valid;
  logic           in_req_rw;
  logic [BEW-1:0] in_req_byteen;
  logic [AW-1:0]  in_req_addr;
  logic [DW-1:0]  in_req_data;
  logic [TW-1:0]  in_req_tag;
  logic           in_req_ready;
  logic           out_req_valid;
  logic           out_req_rw;
  logic [BEW-1:0] out_req_byteen;
  logic [AW-1:0]  out_req_addr;
  logic [DW-1:0]  out_req_data;
  logic [TW-1:0]  out_req_tag;
  logic           out_req_ready;
  logic           rd_rsp_fire;
  logic [NB-1:0]  wr_rsp_fire;
  logic           flush_req;
  logic           flush_ack;
  logic [RCW-1:0] rd_pending;
  logic [WCW-1:0] wr_pending;

  int vectors    = 0;
  int miscompares = 0;

  // reference model
  int mdl_rd    = 0;
  int mdl_wr    = 0;
  int mdl_phase = P_OPEN;

  always #5 clk = ~clk;

  mem_req_fence_gate #(
    .DATA_WIDTH     (DW),
    .ADDR_WIDTH     (AW),
    .TAG_WIDTH      (TW),
    .NUM_BANKS      (NB),
    .MAX_RD_PENDING (MAXR),
    .MAX_WR_PENDING (MAXW)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .in_req_valid   (in_req_valid),
    .in_req_rw      (in_req_rw),
    .in_req_byteen  (in_req_byteen),
    .in_req_addr    (in_req_addr),
    .in_req_data    (in_req_data),
    .in_req_tag     (in_req_tag),
    .in_req_ready   (in_req_ready),
    .out_req_valid  (out_req_valid),
    .out_req_rw     (out_req_rw),
    .out_req_byteen (out_req_byteen),
    .out_req_addr   (out_req_addr),
    .out_req_data   (out_req_data),
    .out_req_tag    (out_req_tag),
    .out_req_ready  (out_req_ready),
    .rd_rsp_fire    (rd_rsp_fire),
    .wr_rsp_fire    (wr_rsp_fire),
    .flush_req      (flush_req),
    .flush_ack      (flush_ack),
    .rd_pending     (rd_pending),
    .wr_pending     (wr_pending)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic drive(input logic v, input logic rw_i, input logic ordy, input logic rsp,
                       input logic [NB-1:0] wrsp, input logic fl, input logic rst_i);
    in_req_valid  = v;
    in_req_rw     = rw_i;
    in_req_byteen = BEW'($urandom);
    in_req_addr   = AW'($urandom);
    in_req_data   = {32'($urandom), 32'($urandom)};
    in_req_tag    = TW'($urandom);
    out_req_ready = ordy;
    rd_rsp_fire   = rsp;
    wr_rsp_fire   = wrsp;
    flush_req     = fl;
    reset         = rst_i;
  endtask

  function automatic bit model_allow();
    if (mdl_phase != P_OPEN) return 1'b0;
    if (in_req_rw) return (mdl_wr < MAXW);
    return (mdl_rd < MAXR);
  endfunction

  // One clock: check pass-through outputs, clock, advance model, check registers
  task automatic step(input string tag);
    bit al;
    bit fire;
    int nrd;
    int nwr;
    #2;
    al = model_allow();
    chk({tag, "/out_valid"}, 128'(out_req_valid), 128'(in_req_valid && al));
    chk({tag, "/in_ready"}, 128'(in_req_ready), 128'(out_req_ready && al));
    chk({tag, "/payload"},
        128'({out_req_rw, out_req_byteen, out_req_addr, out_req_data, out_req_tag}),
        128'({in_req_rw, in_req_byteen, in_req_addr, in_req_data, in_req_tag}));
    fire = in_req_valid && out_req_ready && al;
    @(posedge clk);
    if (!reset) begin
      mdl_rd = 0;
      mdl_wr = 0;
      mdl_phase = P_OPEN;
    end else begin
      nrd = mdl_rd + ((fire && !in_req_rw) ? 1 : 0) - (rd_rsp_fire ? 1 : 0);
      nwr = mdl_wr + ((fire && in_req_rw) ? 1 : 0) - $countones(wr_rsp_fire);
      if (nrd < 0) nrd = 0;
      if (nwr < 0) nwr = 0;
      if (mdl_phase == P_OPEN) begin
        if (flush_req) mdl_phase = P_FENCE;
      end else if (mdl_phase == P_FENCE) begin
        if (nrd == 0 && nwr == 0) mdl_phase = P_ACKED;
      end else begin
        if (!flush_req) mdl_phase = P_OPEN;
      end
      mdl_rd = nrd;
      mdl_wr = nwr;
    end
    #1;
    chk({tag, "/rd_pending"}, 128'(rd_pending), 128'(mdl_rd));
    chk({tag, "/wr_pending"}, 128'(wr_pending), 128'(mdl_wr));
    chk({tag, "/flush_ack"}, 128'(flush_ack), 128'(mdl_phase == P_ACKED));
  endtask

  initial begin
    bit fl_lvl;
    logic [NB-1:0] wb;
    // bring the design out of an unknown state without checking
    drive(1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    step("reset");

    // reset in the middle of traffic
    drive(1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1);
    step("idle");
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1);
      step("rd_issue");
    end
    chk("three_reads", 128'(rd_pending), 128'(3));
    drive(1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
    step("mid_reset");
    chk("mid_reset_rd0", 128'(rd_pending), 128'(0));
    drive(1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1);
    step("post_reset_rdy1");
    drive(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1);
    step("post_reset_rdy0");

    // read limit
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1);
      step("rd_fill");
    end
    chk("rd_at_limit", 128'(rd_pending), 128'(MAXR));
    drive(1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1);
    step("rd_held");
    chk("rd_held_ready", 128'(in_req_ready), 128'(0));
    drive(1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 1'b1);
    step("rd_retire_at_limit");
    chk("rd_after_retire", 128'(rd_pending), 128'(MAXR - 1));
    drive(1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1);
    step("rd_fifth");
    chk("rd_back_to_limit", 128'(rd_pending), 128'(MAXR));

    // simultaneous events
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 1'b1);
      step("rd_drain");
    end
    drive(1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 1'b1);
    step("rd_fire_and_rsp");
    chk("rd_unchanged", 128'(rd_pending), 128'(2));
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1);
      step("wr_issue");
    end
    drive(1'b0, 1'b1, 1'b1, 1'b0, 2'b11, 1'b0, 1'b1);
    step("wr_two_banks");
    chk("wr_zero", 128'(wr_pending), 128'(0));
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 1'b1);
      step("rd_clear");
    end

    // flush with two writes outstanding
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1);
      step("wr_issue2");
    end
    drive(1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 1'b1, 1'b1);
    step("flush_start");
    drive(1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 1'b1, 1'b1);
    step("flush_blocked");
    drive(1'b1, 1'b1, 1'b1, 1'b0, 2'b01, 1'b1, 1'b1);
    step("flush_b0");
    chk("ack_not_yet", 128'(flush_ack), 128'(0));
    drive(1'b1, 1'b1, 1'b1, 1'b0, 2'b10, 1'b1, 1'b1);
    step("flush_b1");
    chk("ack_after_last", 128'(flush_ack), 128'(1));
    drive(1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 1'b1, 1'b1);
    step("flush_hold");
    drive(1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1);
    step("flush_release");
    chk("ack_dropped", 128'(flush_ack), 128'(0));
    drive(1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1);
    step("traffic_resumes");
    chk("wr_resumed", 128'(wr_pending), 128'(1));
    drive(1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 1'b0, 1'b1);
    step("wr_retire");

    // flush while idle: acknowledge two cycles after the request
    drive(1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b1, 1'b1);
    step("idle_flush_1");
    chk("idle_flush_no_ack", 128'(flush_ack), 128'(0));
    step("idle_flush_2");
    chk("idle_flush_ack", 128'(flush_ack), 128'(1));
    drive(1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1);
    step("idle_flush_release");

    // retire with nothing outstanding: count must stay at zero
    drive(1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 1'b1);
    step("underflow");
    chk("underflow_rd0", 128'(rd_pending), 128'(0));

    // random traffic
    fl_lvl = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(15) == 0) fl_lvl = ~fl_lvl;
      wb = 2'b00;
      if (mdl_wr > 0) wb[0] = 1'($urandom_range(3) == 0);
      if (mdl_wr > 1) wb[1] = 1'($urandom_range(3) == 0);
      drive(1'($urandom_range(3) != 0), 1'($urandom), 1'($urandom_range(4) != 0),
            (mdl_rd > 0) ? 1'($urandom_range(2) == 0) : 1'b0,
            wb, fl_lvl, ($urandom_range(80) == 0) ? 1'b0 : 1'b1);
      step("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
